// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: operand register stage, then result/zero-flag register stage.
// Latency: operands accepted at edge N produce valid_o after edge N+1; 1 op/cycle sustained.
// Backpressure: ready_o = !s1_v | !valid_o | ready_i (combinational path from ready_i, no skid buffer).
module alu_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i_1,
  input  logic [DATA_WIDTH-1:0] data_i_2,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH:0]   data_o,
  output logic                  zero_o
);

  // The opcode map below is exactly 3 bits wide; any other width cannot be decoded.
  generate
    if (SEL_WIDTH != 3) begin : g_bad_sel_width
      $error("alu_pipe: SEL_WIDTH must be 3");
    end
    if (DATA_WIDTH < 2) begin : g_bad_data_width
      $error("alu_pipe: DATA_WIDTH must be at least 2");
    end
  endgenerate

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam logic [DATA_WIDTH:0] ONE_X = {{DATA_WIDTH{1'b0}}, 1'b1};

  // Stage 1 state
  logic                  s1_v;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic [SEL_WIDTH-1:0]  s1_sel;

  // Held low during reset and for the edge that releases it, so ready_o
  // only rises on the first clock edge after reset is removed.
  logic                  rdy_en;

  // Handshake / stall terms
  logic                  s2_adv;
  logic                  s2_load;
  logic                  in_xfer;

  // Combinational ALU result from stage-1 operands
  logic [DATA_WIDTH:0]   a_x;
  logic [DATA_WIDTH:0]   b_x;
  logic [DATA_WIDTH:0]   alu_res;
  logic                  alu_zero;

  assign s2_adv  = !valid_o || ready_i;
  assign s2_load = s1_v && s2_adv;
  assign ready_o = rdy_en && (!s1_v || s2_adv);
  assign in_xfer = valid_i && ready_o;

  // Zero-extension makes the extra MSB act as carry/borrow for the arithmetic ops.
  assign a_x = {1'b0, s1_a};
  assign b_x = {1'b0, s1_b};

  // Decode the opcode held in stage 1 into a DATA_WIDTH+1 result.
  always_comb begin
    alu_res = '0;
    case (s1_sel)
      OP_ADD:  alu_res = a_x + b_x;
      OP_SUB:  alu_res = a_x - b_x;   // MSB set exactly when A < B
      OP_INC:  alu_res = a_x + ONE_X;
      OP_DEC:  alu_res = a_x - ONE_X; // MSB set exactly when A == 0
      OP_AND:  alu_res = a_x & b_x;
      OP_OR:   alu_res = a_x | b_x;
      OP_XOR:  alu_res = a_x ^ b_x;
      OP_NOT:  alu_res = {1'b0, ~s1_a};
      default: alu_res = '0;
    endcase
  end

  // Zero flag looks only at the data bits, never at the carry/borrow bit.
  assign alu_zero = (alu_res[DATA_WIDTH-1:0] == '0);

  // Input-ready enable: low in reset, high from the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // Stage-1 valid: set on accept, cleared when its op moves to stage 2 with no replacement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
    end else if (in_xfer) begin
      s1_v <= 1'b1;
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  // Stage-1 operands: captured only on accept, otherwise held through stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_sel <= '0;
    end else if (in_xfer) begin
      s1_a   <= data_i_1;
      s1_b   <= data_i_2;
      s1_sel <= sel_i;
    end
  end

  // Stage-2 valid: set on load, cleared when the consumer takes the result with nothing behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
    end else if (s2_load) begin
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Stage-2 result and flag: written only on load, so they hold through stalls and idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o <= '0;
      zero_o <= 1'b0;
    end else if (s2_load) begin
      data_o <= alu_res;
      zero_o <= alu_zero;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe against an arithmetic reference queue.
// Latency: checks exact two-edge result latency on directed ops.
// Backpressure: checks stall stability, ready_o drop, ordering and reset flush.
module tb_alu_pipe;

  localparam int W   = 8;
  localparam int MOD = 1 << (W + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_i = 1'b0;
  logic         ready_o;
  logic         valid_o;
  logic         zero_o;
  logic [W-1:0] data_i_1 = '0;
  logic [W-1:0] data_i_2 = '0;
  logic [2:0]   sel_i = '0;
  logic [W:0]   data_o;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];
  int         n_out;
  int         n_in;
  int         rdy_low;
  int         cyc_n;
  int         first_out;
  int         last_out;
  logic       held_vld;
  logic [W:0] held_dat;
  logic       held_zero;

  alu_pipe #(.DATA_WIDTH(W), .SEL_WIDTH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i_1 (data_i_1),
    .data_i_2 (data_i_2),
    .sel_i    (sel_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .zero_o   (zero_o)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic modulo 2^(W+1)
  function automatic logic [W:0] ref_alu(int a, int b, int op);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b + MOD;
      2:       r = a + 1;
      3:       r = a - 1 + MOD;
      4:       r = a & b;
      5:       r = a | b;
      6:       r = a ^ b;
      default: r = (1 << W) - 1 - a;
    endcase
    r = r % MOD;
    return r[W:0];
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge, update model, advance to just after posedge.
  task automatic cycle_step();
    logic [W:0] e;
    @(negedge clk);
    if (held_vld) begin
      check("stall_vld",  32'(valid_o), 32'd1);
      check("stall_dat",  32'(data_o),  32'(held_dat));
      check("stall_zero", 32'(zero_o),  32'(held_zero));
    end
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("extra_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_dat",  32'(data_o), 32'(e));
        check("out_zero", 32'(zero_o), 32'((e % (1 << W)) == 0));
      end
      if (n_out == 0) first_out = cyc_n;
      last_out = cyc_n;
      n_out++;
    end
    if (valid_i && !ready_o) rdy_low++;
    if (valid_i && ready_o) begin
      exp_q.push_back(ref_alu(int'(data_i_1), int'(data_i_2), int'(sel_i)));
      n_in++;
    end
    held_vld  = valid_o && !ready_i;
    held_dat  = data_o;
    held_zero = zero_o;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  // Directed single op through an empty pipe with exact latency check.
  task automatic send_one(string tag, logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op,
                          logic [W:0] exp_dat, logic exp_zero);
    data_i_1 = a;
    data_i_2 = b;
    sel_i    = op;
    valid_i  = 1'b1;
    ready_i  = 1'b1;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, 32'(valid_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld"},  32'(valid_o), 32'd1);
    check({tag, "_dat"},  32'(data_o),  32'(exp_dat));
    check({tag, "_zero"}, 32'(zero_o),  32'(exp_zero));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(bit force_add);
    data_i_1 = W'($urandom);
    data_i_2 = W'($urandom);
    sel_i    = force_add ? 3'd0 : 3'($urandom);
  endtask

  initial begin
    held_vld = 1'b0;
    held_dat = '0;
    held_zero = 1'b0;
    n_out = 0; n_in = 0; rdy_low = 0; cyc_n = 0; first_out = 0; last_out = 0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data",  32'(data_o),  32'd0);
    check("rst_zero",  32'(zero_o),  32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready_low", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1;
    check("rel_ready_high", 32'(ready_o), 32'd1);

    // Directed ops
    send_one("add",  8'd200,  8'd100,  3'd0, 9'h12C, 1'b0);
    send_one("sub",  8'd5,    8'd7,    3'd1, 9'h1FE, 1'b0);
    send_one("dec",  8'd0,    8'd0,    3'd3, 9'h1FF, 1'b0);
    send_one("inc",  8'd255,  8'd0,    3'd2, 9'h100, 1'b1);
    send_one("and",  8'hF0,   8'h0F,   3'd4, 9'h000, 1'b1);
    send_one("xor",  8'hAA,   8'hFF,   3'd6, 9'h055, 1'b0);
    send_one("not",  8'h00,   8'h00,   3'd7, 9'h0FF, 1'b0);
    send_one("or",   8'h81,   8'h18,   3'd5, 9'h099, 1'b0);

    // Back-to-back stream of 16 ADDs
    n_out = 0; n_in = 0; rdy_low = 0; cyc_n = 0;
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_ops(1'b1);
      valid_i = 1'b1;
      cycle_step();
    end
    valid_i = 1'b0;
    repeat (4) cycle_step();
    check("stream_rdy_low", 32'(rdy_low), 32'd0);
    check("stream_count",   32'(n_out),   32'd16);
    check("stream_spacing", 32'(last_out - first_out), 32'd15);
    check("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: consumer stalled for 5 cycles
    n_out = 0; n_in = 0; rdy_low = 0;
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_ops(1'b0);
      cycle_step();
    end
    check("bp_accepts", 32'(n_in),    32'd2);
    check("bp_rdy_low", 32'(rdy_low), 32'd3);
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (5) cycle_step();
    check("bp_count",   32'(n_out), 32'd2);
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Random traffic on both sides
    n_out = 0; n_in = 0;
    for (int i = 0; i < 400; i++) begin
      rand_ops(1'b0);
      valid_i = ($urandom_range(0, 9) < 7);
      ready_i = ($urandom_range(0, 9) < 6);
      cycle_step();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || valid_o); i++) cycle_step();
    check("rand_q_empty", 32'(exp_q.size()), 32'd0);
    check("rand_in_out",  32'(n_out), 32'(n_in));

    // Reset with two ops in flight
    ready_i = 1'b0;
    valid_i = 1'b1;
    rand_ops(1'b0);
    cycle_step();
    rand_ops(1'b0);
    cycle_step();
    valid_i = 1'b0;
    check("inflight_vld", 32'(valid_o), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_data",  32'(data_o),  32'd0);
    check("mid_rst_zero",  32'(zero_o),  32'd0);
    check("mid_rst_ready", 32'(ready_o), 32'd0);
    exp_q.delete();
    held_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    n_out = 0;
    repeat (6) cycle_step();
    check("post_rst_no_out", 32'(n_out), 32'd0);
    send_one("post_rst_sub", 8'd9, 8'd3, 3'd1, 9'h006, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
